// File: rtl/window_scheduler_if.sv
// Bundle of job-control, write-strobe and window-handshake signals between
// the window scheduler and its producer/consumer environment.
interface window_scheduler_if #(
    parameter int SIZE  = 16,
    parameter int K     = 4,
    parameter int CNT_W = 8
);
    localparam int PTR_W  = $clog2(SIZE);
    localparam int OCC_W  = $clog2(SIZE) + 1;
    localparam int STEP_W = $clog2(K) + 1;

    logic              start;
    logic [CNT_W-1:0]  n_win;
    logic [STEP_W-1:0] step;
    logic              wr_en;
    logic              win_ready;
    logic              win_valid;
    logic [PTR_W-1:0]  win_base;
    logic [OCC_W-1:0]  occupancy;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, n_win, step, wr_en, win_ready,
        input  win_valid, win_base, occupancy, busy, done, overflow
    );

    modport slave (
        input  start, n_win, step, wr_en, win_ready,
        output win_valid, win_base, occupancy, busy, done, overflow
    );
endinterface

// File: rtl/window_scheduler.sv
// Sliding-window scheduler over a circular buffer: tracks occupancy from a
// write strobe and issues K-wide window base indices, advancing by a clamped
// step after each consumer handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; writes ignored
// S_WAIT_DATA | collecting writes until at least K unread elements exist
// S_ISSUE     | win_valid held with win_base until the consumer accepts
// S_DONE      | one-cycle done pulse, then back to S_IDLE
module window_scheduler #(
    parameter int SIZE  = 16,
    parameter int K     = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    window_scheduler_if.slave bus
);
    localparam int PTR_W  = $clog2(SIZE);
    localparam int OCC_W  = $clog2(SIZE) + 1;
    localparam int STEP_W = $clog2(K) + 1;
    localparam int SUM_W  = PTR_W + 1;

    localparam logic [STEP_W-1:0] K_STEP   = STEP_W'(K);
    localparam logic [OCC_W-1:0]  K_OCC    = OCC_W'(K);
    localparam logic [OCC_W-1:0]  SIZE_OCC = OCC_W'(SIZE);
    localparam logic [SUM_W-1:0]  SIZE_SUM = SUM_W'(SIZE);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_win_q, n_win_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              overflow_q, overflow_d;
    logic              win_valid_q, win_valid_d;
    logic [PTR_W-1:0]  win_base_q, win_base_d;

    logic [STEP_W-1:0] step_clamp;
    logic [SUM_W-1:0]  rd_sum;
    logic [PTR_W-1:0]  rd_next;
    logic              hs;
    logic              active;
    logic              wr_ok;
    logic              wr_acc;
    logic              last_win;

    // Clamp the requested step into 1..K so occupancy can never underflow.
    always_comb begin
        step_clamp = bus.step;
        if (bus.step == '0) begin
            step_clamp = STEP_W'(1);
        end else if (bus.step > K_STEP) begin
            step_clamp = K_STEP;
        end
    end

    // Pointer advance wraps by compare-and-subtract so SIZE need not be 2^n.
    assign rd_sum   = {1'b0, rd_ptr_q} + SUM_W'(step_q);
    assign rd_next  = (rd_sum >= SIZE_SUM) ? PTR_W'(rd_sum - SIZE_SUM) : PTR_W'(rd_sum);
    assign hs       = (state_q == S_ISSUE) && win_valid_q && bus.win_ready;
    assign active   = (state_q == S_WAIT_DATA) || (state_q == S_ISSUE);
    assign wr_ok    = active && bus.wr_en;
    assign wr_acc   = wr_ok && (occ_q < SIZE_OCC);
    assign last_win = (win_cnt_q == n_win_q - CNT_W'(1));

    // Next-state, pointer and occupancy logic.
    always_comb begin
        state_d     = state_q;
        n_win_d     = n_win_q;
        step_d      = step_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        win_cnt_d   = win_cnt_q;
        overflow_d  = overflow_q;
        win_valid_d = win_valid_q;
        win_base_d  = win_base_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_win_d    = bus.n_win;
                    step_d     = step_clamp;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    occ_d      = '0;
                    win_cnt_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = (bus.n_win == '0) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (occ_q >= K_OCC) begin
                    state_d     = S_ISSUE;
                    win_valid_d = 1'b1;
                    win_base_d  = rd_ptr_q;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    win_valid_d = 1'b0;
                    rd_ptr_d    = rd_next;
                    win_cnt_d   = win_cnt_q + CNT_W'(1);
                    state_d     = last_win ? S_DONE : S_WAIT_DATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Full check uses the pre-update occupancy, even on a handshake cycle.
        if (wr_ok) begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (active) begin
            occ_d = occ_q + OCC_W'(wr_acc) - (hs ? OCC_W'(step_q) : '0);
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            n_win_q     <= '0;
            step_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            win_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_win_q     <= n_win_d;
            step_q      <= step_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            win_cnt_q   <= win_cnt_d;
            overflow_q  <= overflow_d;
            win_valid_q <= win_valid_d;
            win_base_q  <= win_base_d;
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_base  = win_base_q;
    assign bus.occupancy = occ_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = active;
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler (SIZE=16, K=4).
module tb_window_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int   got_bases[16];
    int   n_got;
    int   n_done;
    bit   ovf_seen;
    bit   busy_seen;

    window_scheduler_if #(.SIZE(16), .K(4), .CNT_W(8)) bus ();

    window_scheduler #(.SIZE(16), .K(4), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.n_win     = '0;
        bus.step      = '0;
        bus.wr_en     = 1'b0;
        bus.win_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic start_job(input int n, input int s);
        bus.start = 1'b1;
        bus.n_win = 8'(n);
        bus.step  = 3'(s);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Runs a job with win_ready high and `writes` write strobes, recording windows.
    task automatic run_job(input int n, input int s, input int writes);
        int wleft;
        start_job(n, s);
        n_got = 0; n_done = 0; ovf_seen = 0; busy_seen = 0;
        wleft = writes;
        for (int c = 0; c < 300; c++) begin
            if (bus.win_valid) begin
                if (n_got < 16) got_bases[n_got] = int'(bus.win_base);
                n_got++;
            end
            if (bus.done) n_done++;
            if (bus.overflow) ovf_seen = 1;
            if (bus.busy) busy_seen = 1;
            if (n_done > 0 && !bus.done) break;
            bus.wr_en     = (wleft > 0);
            bus.win_ready = 1'b1;
            if (wleft > 0) wleft--;
            @(negedge clk);
        end
        bus.wr_en     = 1'b0;
        bus.win_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.win_base !== 4'd0 || bus.occupancy !== 5'd0) begin
            failures++;
            $display("FAIL reset_data valid=%0b base=%0d occ=%0d exp 0/0/0",
                     bus.win_valid, bus.win_base, bus.occupancy);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%0b done=%0b ovf=%0b exp 0/0/0",
                     bus.busy, bus.done, bus.overflow);
        end
    endtask

    task automatic test_idle_write();
        bus.wr_en = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.occupancy !== 5'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_write occ=%0d busy=%0b exp 0/0", bus.occupancy, bus.busy);
        end
    endtask

    task automatic test_basic();
        run_job(2, 4, 8);
        checks++;
        if (n_got !== 2 || n_done !== 1) begin
            failures++;
            $display("FAIL basic_count windows=%0d dones=%0d exp 2/1", n_got, n_done);
        end
        checks++;
        if (got_bases[0] !== 0 || got_bases[1] !== 4) begin
            failures++;
            $display("FAIL basic_bases got %0d,%0d exp 0,4", got_bases[0], got_bases[1]);
        end
        checks++;
        if (bus.occupancy !== 5'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end occ=%0d busy=%0b exp 0/0", bus.occupancy, bus.busy);
        end
    endtask

    task automatic test_stride3();
        int exp_b[6] = '{0, 3, 6, 9, 12, 15};
        run_job(6, 3, 1000);
        checks++;
        if (n_got !== 6 || n_done !== 1 || ovf_seen !== 1'b0) begin
            failures++;
            $display("FAIL stride3_count windows=%0d dones=%0d ovf=%0b exp 6/1/0", n_got, n_done, ovf_seen);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_bases[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL stride3_base[%0d] got=%0d exp=%0d", i, got_bases[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_clamp();
        run_job(3, 0, 1000);
        checks++;
        if (n_got !== 3 || got_bases[0] !== 0 || got_bases[1] !== 1 || got_bases[2] !== 2) begin
            failures++;
            $display("FAIL clamp_zero n=%0d bases %0d,%0d,%0d exp 3: 0,1,2",
                     n_got, got_bases[0], got_bases[1], got_bases[2]);
        end
        run_job(3, 7, 1000);
        checks++;
        if (n_got !== 3 || got_bases[0] !== 0 || got_bases[1] !== 4 || got_bases[2] !== 8) begin
            failures++;
            $display("FAIL clamp_big n=%0d bases %0d,%0d,%0d exp 3: 0,4,8",
                     n_got, got_bases[0], got_bases[1], got_bases[2]);
        end
    endtask

    task automatic test_wrap();
        int exp_b[6] = '{0, 4, 8, 12, 0, 4};
        run_job(6, 4, 1000);
        checks++;
        if (n_got !== 6 || n_done !== 1) begin
            failures++;
            $display("FAIL wrap_count windows=%0d dones=%0d exp 6/1", n_got, n_done);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_bases[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL wrap_base[%0d] got=%0d exp=%0d", i, got_bases[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_stall();
        int got;
        start_job(2, 4);
        bus.wr_en = 1'b1;
        repeat (4) @(negedge clk);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 5 && !bus.win_valid; i++) @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_base !== 4'd0) begin
            failures++;
            $display("FAIL stall_issue valid=%0b base=%0d exp 1/0", bus.win_valid, bus.win_base);
        end
        // Hold ready low five cycles; a stray start in ISSUE must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 1);
            bus.n_win = '0;
            @(negedge clk);
            checks++;
            if (bus.win_valid !== 1'b1 || bus.win_base !== 4'd0 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] valid=%0b base=%0d done=%0b exp 1/0/0",
                         i, bus.win_valid, bus.win_base, bus.done);
            end
        end
        bus.start = 1'b0;
        // Release together with a write: 4 + 1 - 4 = 1.
        bus.win_ready = 1'b1;
        bus.wr_en     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.occupancy !== 5'd1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL stall_release valid=%0b occ=%0d busy=%0b done=%0b exp 0/1/1/0",
                     bus.win_valid, bus.occupancy, bus.busy, bus.done);
        end
        got = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.win_valid) begin
                got = int'(bus.win_base);
                break;
            end
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== 4 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL stall_second base=%0d done=%0b exp 4/1", got, bus.done);
        end
        bus.win_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        start_job(0, 4);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_done done=%0b busy=%0b valid=%0b exp 1/0/0",
                     bus.done, bus.busy, bus.win_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_after done=%0b busy=%0b valid=%0b exp 0/0/0",
                     bus.done, bus.busy, bus.win_valid);
        end
    endtask

    task automatic test_overflow();
        start_job(1, 4);
        bus.win_ready = 1'b0;
        bus.wr_en     = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (bus.occupancy !== 5'd16 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full occ=%0d ovf=%0b exp 16/0", bus.occupancy, bus.overflow);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.occupancy !== 5'd16 || bus.overflow !== 1'b1 || bus.win_valid !== 1'b1 || bus.win_base !== 4'd0) begin
            failures++;
            $display("FAIL ovf_drop occ=%0d ovf=%0b valid=%0b base=%0d exp 16/1/1/0",
                     bus.occupancy, bus.overflow, bus.win_valid, bus.win_base);
        end
        bus.win_ready = 1'b1;
        @(negedge clk);
        bus.win_ready = 1'b0;
        checks++;
        if (bus.occupancy !== 5'd12 || bus.done !== 1'b1 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_handshake occ=%0d done=%0b ovf=%0b exp 12/1/1",
                     bus.occupancy, bus.done, bus.overflow);
        end
        @(negedge clk);
        start_job(1, 4);
        checks++;
        if (bus.overflow !== 1'b0 || bus.occupancy !== 5'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear ovf=%0b occ=%0d busy=%0b exp 0/0/1",
                     bus.overflow, bus.occupancy, bus.busy);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_issue();
        bit hit = 0;
        start_job(4, 4);
        for (int c = 0; c < 60; c++) begin
            if (bus.win_valid && bus.win_base == 4'd8) begin
                bus.win_ready = 1'b0;
                hit = 1;
                break;
            end
            bus.win_ready = 1'b1;
            bus.wr_en     = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL midrst_reach base8 reached=%0b exp 1", hit);
        end
        rst = 1'b1;
        bus.start = 1'b1; bus.n_win = 8'd2; bus.step = 3'd4;
        bus.wr_en = 1'b1; bus.win_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.win_base !== 4'd0 || bus.occupancy !== 5'd0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out valid=%0b base=%0d occ=%0d busy=%0b done=%0b ovf=%0b exp all 0",
                     bus.win_valid, bus.win_base, bus.occupancy, bus.busy, bus.done, bus.overflow);
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle busy=%0b done=%0b exp 0/0", bus.busy, bus.done);
        end
        run_job(2, 4, 8);
        checks++;
        if (n_got !== 2 || got_bases[0] !== 0 || got_bases[1] !== 4 || n_done !== 1) begin
            failures++;
            $display("FAIL midrst_fresh n=%0d bases %0d,%0d dones=%0d exp 2: 0,4 / 1",
                     n_got, got_bases[0], got_bases[1], n_done);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_idle_write();
        test_basic();
        test_stride3();
        test_clamp();
        test_wrap();
        test_stall();
        test_zero();
        test_overflow();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 16, circular-buffer depth; any integer >= K (not restricted to powers of two).
REQ-002 SHALL have parameter K, default 4, window width in consecutive indices.
REQ-003 SHALL have parameter CNT_W, default 8, width of the window-count field.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-007 n_win  input  CNT_W  number of windows in the job; sampled on an accepted start.
REQ-008 step  input  $clog2(K)+1  read-pointer advance per window; sampled on an accepted start.
REQ-009 wr_en  input  1  one element written to the buffer this cycle.
REQ-010 win_ready  input  1  consumer accepts the current window.
REQ-011 win_valid  output  1  win_base is valid; registered.
REQ-012 win_base  output  $clog2(SIZE)  first index of the window; drives the index generator num_in.
REQ-013 occupancy  output  $clog2(SIZE)+1  unread elements in the buffer.
REQ-014 busy  output  1  high in WAIT_DATA and ISSUE.
REQ-015 done  output  1  one-cycle pulse at job end.
REQ-016 overflow  output  1  sticky write-drop flag.

Function
REQ-017 SHALL implement four states: IDLE, WAIT_DATA, ISSUE, DONE.
REQ-018 IDLE + start: latch n_win and clamped step (0 -> 1, >K -> K); clear rd_ptr, wr_ptr, occupancy, win_cnt, overflow; next state WAIT_DATA, or DONE if n_win == 0.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 WAIT_DATA: if registered occupancy >= K, next state ISSUE with win_valid=1 and win_base=rd_ptr; otherwise stay.
REQ-021 ISSUE: win_valid and win_base SHALL hold stable until win_valid && win_ready.
REQ-022 On handshake:
  - rd_ptr <= (rd_ptr + step) mod SIZE, wrap by compare-and-subtract;
  - occupancy decreases by step;
  - win_cnt increments;
  - win_valid deasserts next cycle;
  - next state DONE if win_cnt == n_win-1, else WAIT_DATA.
REQ-023 Throughput SHALL be at most one window per 2 cycles (mandatory WAIT_DATA cycle after every handshake).
REQ-024 wr_en in WAIT_DATA or ISSUE with occupancy < SIZE: occupancy +1, wr_ptr <= (wr_ptr+1) mod SIZE.
REQ-025 wr_en with occupancy == SIZE: write dropped, occupancy unchanged, overflow set until next accepted start or rst.
REQ-026 wr_en in IDLE or DONE SHALL be ignored.
REQ-027 Simultaneous wr_en and handshake: occupancy <= occupancy + 1 - step; the full check uses the pre-update value.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-029 Step arithmetic SHALL be unsigned; step is always <= K <= occupancy at handshake, so occupancy cannot underflow.

Reset
REQ-030 rst SHALL force, on the next edge: state IDLE; win_valid=0, win_base=0, occupancy=0, busy=0, done=0, overflow=0; rd_ptr, wr_ptr, win_cnt, latched n_win/step = 0.
REQ-031 rst SHALL take priority over start, wr_en and win_ready in the same cycle, including mid-ISSUE.

Verification (SIZE=16, K=4)
REQ-032 start n_win=2 step=4, 8 writes, win_ready=1 -> win_base 0 then 4, done pulse, occupancy 0, busy low.
REQ-033 start n_win=6 step=3, wr_en held high, win_ready=1 -> win_base 0,3,6,9,12,15; no overflow; one done pulse.
REQ-034 win_ready low 5 cycles in ISSUE at win_base=0 -> win_valid=1 and win_base=0 stable throughout; single advance on release.
REQ-035 start n_win=0 -> done next cycle, win_valid never asserted, busy stays 0.
REQ-036 start n_win=1, win_ready=0, 17 writes -> occupancy 16, overflow=1; after handshake occupancy=12 with step=4.
REQ-037 rst asserted in ISSUE with win_base=8 -> next cycle all outputs 0, state IDLE; a following start behaves as a fresh job.
